// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: hunts for the symbol boundary inside a two-word bit window,
// then decodes each aligned 10-bit symbol into a pixel byte or a control token.
module tmds_channel_decoder #(
    parameter int TOKEN_RUN    = 16,
    parameter int SEARCH_WORDS = 4096,
    parameter int LOCK_TIMEOUT = 8192
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       din_valid,
    input  logic       resync_in,
    output logic [7:0] data_out,
    output logic [1:0] ctrl_out,
    output logic       de_out,
    output logic       out_valid,
    output logic       locked,
    output logic [3:0] offset_out
);
    localparam int RUN_W  = $clog2(TOKEN_RUN) + 1;
    localparam int WORD_W = $clog2(SEARCH_WORDS) + 1;
    localparam int SIL_W  = $clog2(LOCK_TIMEOUT) + 1;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]        state_reg, state_next;
    logic [3:0]        offset_reg, offset_next;
    logic [RUN_W-1:0]  run_reg, run_next;
    logic [WORD_W-1:0] word_reg, word_next;
    logic [SIL_W-1:0]  sil_reg, sil_next;
    logic [9:0]        prev_reg, prev_next;
    logic [7:0]        data_reg, data_next;
    logic [1:0]        ctrl_reg, ctrl_next;
    logic              de_reg, de_next;
    logic              valid_reg, valid_next;

    // Offset 0 selects the previous word in full; higher offsets pull in bits of din.
    logic [18:0] window;
    logic [9:0]  cand [10];
    logic [9:0]  q;

    assign window = {din[8:0], prev_reg};

    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_cand
            assign cand[gi] = window[gi+9:gi];
        end
    endgenerate

    assign q = (offset_reg < 4'd10) ? cand[offset_reg] : cand[0];

    logic       is_token;
    logic [1:0] token_ctrl;

    always_comb begin
        is_token   = 1'b1;
        token_ctrl = 2'b00;
        case (q)
            10'h354: token_ctrl = 2'b00;
            10'h0AB: token_ctrl = 2'b01;
            10'h154: token_ctrl = 2'b10;
            10'h2AB: token_ctrl = 2'b11;
            default: is_token = 1'b0;
        endcase
    end

    logic [7:0] d;
    logic [7:0] decoded;

    assign d          = q[9] ? ~q[7:0] : q[7:0];
    assign decoded[0] = d[0];

    generate
        for (genvar gi = 1; gi < 8; gi++) begin : g_dec
            assign decoded[gi] = q[8] ? (d[gi] ^ d[gi-1]) : ~(d[gi] ^ d[gi-1]);
        end
    endgenerate

    logic [RUN_W-1:0]  run_inc;
    logic [WORD_W-1:0] word_inc;
    logic [SIL_W-1:0]  sil_inc;
    logic [3:0]        offset_adv;

    assign run_inc    = (&run_reg)  ? run_reg  : run_reg  + RUN_W'(1);
    assign word_inc   = (&word_reg) ? word_reg : word_reg + WORD_W'(1);
    assign sil_inc    = (&sil_reg)  ? sil_reg  : sil_reg  + SIL_W'(1);
    assign offset_adv = (offset_reg >= 4'd9) ? 4'd0 : offset_reg + 4'd1;

    always_comb begin
        state_next  = state_reg;
        offset_next = offset_reg;
        run_next    = run_reg;
        word_next   = word_reg;
        sil_next    = sil_reg;
        prev_next   = prev_reg;
        data_next   = data_reg;
        ctrl_next   = ctrl_reg;
        de_next     = de_reg;
        valid_next  = din_valid;

        if (resync_in) begin
            state_next = ST_SEARCH;
            run_next   = '0;
            word_next  = '0;
            sil_next   = '0;
            data_next  = '0;
            ctrl_next  = '0;
            de_next    = 1'b0;
            valid_next = 1'b0;
        end else if (din_valid) begin
            prev_next = din;
            if (state_reg == ST_SEARCH) begin
                data_next = '0;
                ctrl_next = '0;
                de_next   = 1'b0;
                word_next = word_inc;
                run_next  = is_token ? run_inc : '0;
                if (is_token && run_inc == RUN_W'(TOKEN_RUN)) begin
                    state_next = ST_LOCKED;
                    run_next   = '0;
                    sil_next   = '0;
                end else if (word_reg == WORD_W'(SEARCH_WORDS - 1)) begin
                    offset_next = offset_adv;
                    word_next   = '0;
                    run_next    = '0;
                end
            end else if (is_token) begin
                ctrl_next = token_ctrl;
                de_next   = 1'b0;
                data_next = '0;
                sil_next  = '0;
            end else begin
                data_next = decoded;
                de_next   = 1'b1;
                sil_next  = sil_inc;
                // Too long without a control token: alignment presumed wrong, try the next offset.
                if (sil_inc == SIL_W'(LOCK_TIMEOUT)) begin
                    state_next  = ST_SEARCH;
                    offset_next = offset_adv;
                    run_next    = '0;
                    word_next   = '0;
                    sil_next    = '0;
                    data_next   = '0;
                    ctrl_next   = '0;
                    de_next     = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_SEARCH;
            offset_reg <= '0;
            run_reg    <= '0;
            word_reg   <= '0;
            sil_reg    <= '0;
            prev_reg   <= '0;
            data_reg   <= '0;
            ctrl_reg   <= '0;
            de_reg     <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            offset_reg <= offset_next;
            run_reg    <= run_next;
            word_reg   <= word_next;
            sil_reg    <= sil_next;
            prev_reg   <= prev_next;
            data_reg   <= data_next;
            ctrl_reg   <= ctrl_next;
            de_reg     <= de_next;
            valid_reg  <= valid_next;
        end
    end

    assign data_out   = data_reg;
    assign ctrl_out   = ctrl_reg;
    assign de_out     = de_reg;
    assign out_valid  = valid_reg;
    assign locked     = (state_reg == ST_LOCKED);
    assign offset_out = offset_reg;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: directed symbol streams at chosen bit delays,
// a per-cycle behavioural model, plus literal expectations at key points.
module tb_tmds_channel_decoder;
    localparam int TOKEN_RUN    = 16;
    localparam int SEARCH_WORDS = 4096;
    localparam int LOCK_TIMEOUT = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic       din_valid = 1'b0;
    logic       resync_in = 1'b0;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       out_valid;
    logic       locked;
    logic [3:0] offset_out;

    always #5 clk = ~clk;

    tmds_channel_decoder #(
        .TOKEN_RUN(TOKEN_RUN),
        .SEARCH_WORDS(SEARCH_WORDS),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .din(din),
        .din_valid(din_valid),
        .resync_in(resync_in),
        .data_out(data_out),
        .ctrl_out(ctrl_out),
        .de_out(de_out),
        .out_valid(out_valid),
        .locked(locked),
        .offset_out(offset_out)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    bit         m_ready = 1'b0;
    bit         m_locked = 1'b0;
    int         m_off = 0, m_run = 0, m_words = 0, m_sil = 0;
    logic [9:0] m_prev = '0;
    logic [7:0] e_data = '0;
    logic [1:0] e_ctrl = '0;
    logic       e_de = 1'b0, e_val = 1'b0;

    function automatic int token_of(input logic [9:0] s);
        case (s)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] tmds_decode(input logic [9:0] s);
        logic [7:0] dd, r;
        dd = s[9] ? ~s[7:0] : s[7:0];
        r[0] = dd[0];
        for (int i = 1; i < 8; i++) r[i] = s[8] ? (dd[i] ^ dd[i-1]) : ~(dd[i] ^ dd[i-1]);
        return r;
    endfunction

    always @(posedge clk) begin : model
        logic [19:0] win;
        logic [9:0]  sym;
        int          tok;
        m_ready = 1'b1;
        if (rst) begin
            m_locked = 0; m_off = 0; m_run = 0; m_words = 0; m_sil = 0; m_prev = '0;
            e_data = '0; e_ctrl = '0; e_de = 0; e_val = 0;
        end else if (resync_in) begin
            m_locked = 0; m_run = 0; m_words = 0; m_sil = 0;
            e_data = '0; e_ctrl = '0; e_de = 0; e_val = 0;
        end else if (!din_valid) begin
            e_val = 0;
        end else begin
            e_val = 1;
            win = {din, m_prev};
            sym = win[m_off +: 10];
            m_prev = din;
            tok = token_of(sym);
            if (!m_locked) begin
                m_words++;
                m_run = (tok >= 0) ? m_run + 1 : 0;
                if (m_run == TOKEN_RUN) begin
                    m_locked = 1; m_run = 0; m_sil = 0;
                end else if (m_words == SEARCH_WORDS) begin
                    m_off = (m_off + 1) % 10; m_words = 0; m_run = 0;
                end
            end else if (tok >= 0) begin
                e_ctrl = tok[1:0]; e_de = 0; e_data = '0; m_sil = 0;
            end else begin
                e_data = tmds_decode(sym); e_de = 1; m_sil++;
                if (m_sil == LOCK_TIMEOUT) begin
                    m_locked = 0; m_off = (m_off + 1) % 10;
                    m_run = 0; m_words = 0; m_sil = 0;
                    e_data = '0; e_ctrl = '0; e_de = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            checks++;
            if (data_out !== e_data || ctrl_out !== e_ctrl || de_out !== e_de ||
                out_valid !== e_val || locked !== m_locked || offset_out !== 4'(m_off)) begin
                errors++;
                $display("FAIL model_cmp t=%0t data=%h/%h ctrl=%0d/%0d de=%b/%b valid=%b/%b locked=%b/%b offset=%0d/%0d (actual/required)",
                         $time, data_out, e_data, ctrl_out, e_ctrl, de_out, e_de,
                         out_valid, e_val, locked, m_locked, offset_out, m_off);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [9:0] last_sym = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    task automatic cyc(input logic [9:0] w, input logic v);
        din = w;
        din_valid = v;
        @(posedge clk);
        #1;
    endtask

    // Sends one symbol on a stream that lags the word boundary by dly bits.
    task automatic send(input logic [9:0] sym, input int dly);
        logic [19:0] pair;
        pair = {sym, last_sym};
        last_sym = sym;
        cyc(10'(pair >> (10 - dly)), 1'b1);
    endtask

    task automatic idle();
        cyc(din, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc('0, 1'b0);
        rst = 1'b0;
        last_sym = '0;
    endtask

    initial begin
        int  n;
        int  prev_off;
        bit  seq_ok;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_locked", 32'(locked), 0);
        chk("reset_data", 32'(data_out), 0);
        chk("reset_valid", 32'(out_valid), 0);
        chk("reset_offset", 32'(offset_out), 0);
        rst = 1'b0;

        // Offset 0: sixteen 0x354 tokens then two data symbols
        for (int i = 0; i < 16; i++) send(10'h354, 0);
        chk("t1_not_yet_locked", 32'(locked), 0);
        send(10'h100, 0);
        chk("t1_locked", 32'(locked), 1);
        chk("t1_ctrl", 32'(ctrl_out), 0);
        send(10'h200, 0);
        chk("t1_data_00", 32'(data_out), 32'h00);
        chk("t1_de", 32'(de_out), 1);
        send(10'h100, 0);
        chk("t1_data_ff", 32'(data_out), 32'hFF);

        // Gaps in din_valid hold the decoded outputs
        idle();
        chk("t6_gap_data", 32'(data_out), 32'hFF);
        chk("t6_gap_de", 32'(de_out), 1);
        chk("t6_gap_valid", 32'(out_valid), 0);
        send(10'h100, 0);
        chk("t6_data_00", 32'(data_out), 32'h00);
        chk("t6_valid", 32'(out_valid), 1);
        idle();
        chk("t6_gap2_data", 32'(data_out), 32'h00);
        send(10'h2AB, 0);
        send(10'h2AB, 0);
        chk("t6_ctrl_11", 32'(ctrl_out), 3);
        chk("t6_ctrl_de", 32'(de_out), 0);

        // Resync pulse with a valid word in the same cycle
        resync_in = 1'b1;
        cyc(10'h354, 1'b1);
        resync_in = 1'b0;
        chk("t5_resync_locked", 32'(locked), 0);
        chk("t5_resync_ctrl", 32'(ctrl_out), 0);
        chk("t5_resync_valid", 32'(out_valid), 0);
        chk("t5_resync_offset", 32'(offset_out), 0);

        // Broken run: 15 tokens, a data word, then an unbroken run
        do_reset();
        for (int i = 0; i < 15; i++) send(10'h354, 0);
        send(10'h100, 0);
        for (int i = 0; i < 16; i++) send(10'h354, 0);
        chk("t3_no_lock_after_broken_run", 32'(locked), 0);
        send(10'h354, 0);
        chk("t3_lock_after_full_run", 32'(locked), 1);

        // Stream delayed by 3 bits: offset steps 0,1,2,3 then locks
        do_reset();
        n = 0;
        prev_off = 0;
        seq_ok = 1'b1;
        while (!locked && n < 3 * SEARCH_WORDS + 40) begin
            send(10'h2AB, 3);
            n++;
            if (int'(offset_out) != prev_off) begin
                if (int'(offset_out) != prev_off + 1) seq_ok = 1'b0;
                prev_off = int'(offset_out);
            end
        end
        chk("t2_locked", 32'(locked), 1);
        chk("t2_offset", 32'(offset_out), 3);
        chk("t2_offset_steps", 32'(seq_ok), 1);
        chk("t2_words_within_bound", 32'(n <= 3 * SEARCH_WORDS + 16), 1);
        send(10'h2AB, 3);
        chk("t2_ctrl_11", 32'(ctrl_out), 3);

        // 8192 non-token symbols (with valid gaps) drop the lock
        for (int i = 1; i <= LOCK_TIMEOUT + 1; i++) begin
            send(10'h100, 3);
            if (i == LOCK_TIMEOUT) begin
                chk("t4_still_locked", 32'(locked), 1);
                chk("t4_de_before_drop", 32'(de_out), 1);
            end
            if (i % 512 == 0) idle();
        end
        chk("t4_lock_dropped", 32'(locked), 0);
        chk("t4_de_cleared", 32'(de_out), 0);
        chk("t4_offset_advanced", 32'(offset_out), 4);

        // Relock at offset 4, then reset mid-lock
        n = 0;
        while (!locked && n < 60) begin
            send(10'h354, 4);
            n++;
        end
        chk("t5_relock", 32'(locked), 1);
        chk("t5_relock_offset", 32'(offset_out), 4);
        send(10'h100, 4);
        send(10'h100, 4);
        chk("t5_data_de", 32'(de_out), 1);
        rst = 1'b1;
        resync_in = 1'b1;
        cyc(10'h100, 1'b1);
        rst = 1'b0;
        resync_in = 1'b0;
        chk("t5_rst_locked", 32'(locked), 0);
        chk("t5_rst_de", 32'(de_out), 0);
        chk("t5_rst_valid", 32'(out_valid), 0);
        chk("t5_rst_offset", 32'(offset_out), 0);

        idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
